// File: rtl/feature_fifo_dispatcher.sv
// rtl/feature_fifo_dispatcher.sv - round-robin / broadcast feature-vector dispatcher
// Feeds NUM_CH downstream lane FIFOs through a one-cycle output register.
module feature_fifo_dispatcher #(
  parameter int DATA_W = 256,
  parameter int NUM_CH = 4,
  parameter int PTR_W  = $clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_feature,
  input  logic              i_feature_valid,
  output logic              o_feature_ready,
  input  logic              i_mode,
  input  logic              i_ptr_clear,
  input  logic [NUM_CH-1:0] i_fifo_full,
  output logic [DATA_W-1:0] o_feature_fifo,
  output logic [NUM_CH-1:0] o_feature_fifo_valid,
  output logic [PTR_W-1:0]  o_lane_ptr,
  output logic [CNT_W-1:0]  o_beat_cnt
);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [NUM_CH-1:0] lane_sel;
  logic              target_full;
  logic              accept;

  // Decode by comparison so a non-power-of-two NUM_CH never indexes past the last lane.
  always_comb begin
    lane_sel    = '0;
    target_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ptr == PTR_W'(i)) begin
        lane_sel[i] = 1'b1;
        target_full = i_fifo_full[i];
      end
    end
  end

  assign ptr_next        = (ptr == PTR_W'(NUM_CH - 1)) ? '0 : ptr + PTR_W'(1);
  assign o_feature_ready = i_mode ? ~|i_fifo_full : ~target_full;
  assign accept          = i_feature_valid & o_feature_ready;
  assign o_lane_ptr      = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                  <= '0;
      o_beat_cnt           <= '0;
      o_feature_fifo       <= '0;
      o_feature_fifo_valid <= '0;
    end else begin
      o_feature_fifo_valid <= '0;
      if (accept) begin
        o_feature_fifo       <= i_feature;
        o_feature_fifo_valid <= i_mode ? {NUM_CH{1'b1}} : lane_sel;
      end
      // A clear wins over the count/advance of a beat dispatched in the same cycle.
      if (i_ptr_clear) begin
        ptr        <= '0;
        o_beat_cnt <= '0;
      end else if (accept) begin
        o_beat_cnt <= o_beat_cnt + CNT_W'(1);
        if (!i_mode) begin
          ptr <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_feature_fifo_dispatcher.sv
// tb/tb_feature_fifo_dispatcher.sv - bench for feature_fifo_dispatcher
// Two instances (4 lanes / 3 lanes with a narrow counter) checked against an integer model.
module tb_feature_fifo_dispatcher;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] din [2];
  logic          vin [2];
  logic          mdin[2];
  logic          cin [2];
  logic [3:0]    fin [2];

  logic          r0, r1;
  logic [DW-1:0] q0, q1;
  logic [3:0]    qv0;
  logic [2:0]    qv1;
  logic [1:0]    p0, p1;
  logic [15:0]   bc0;
  logic [3:0]    bc1;

  feature_fifo_dispatcher #(.DATA_W(DW), .NUM_CH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .i_feature(din[0]), .i_feature_valid(vin[0]),
    .o_feature_ready(r0), .i_mode(mdin[0]), .i_ptr_clear(cin[0]),
    .i_fifo_full(fin[0]), .o_feature_fifo(q0), .o_feature_fifo_valid(qv0),
    .o_lane_ptr(p0), .o_beat_cnt(bc0)
  );

  feature_fifo_dispatcher #(.DATA_W(DW), .NUM_CH(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .i_feature(din[1]), .i_feature_valid(vin[1]),
    .o_feature_ready(r1), .i_mode(mdin[1]), .i_ptr_clear(cin[1]),
    .i_fifo_full(fin[1][2:0]), .o_feature_fifo(q1), .o_feature_fifo_valid(qv1),
    .o_lane_ptr(p1), .o_beat_cnt(bc1)
  );

  int vectors = 0;
  int miscompares = 0;
  int nch [2] = '{4, 3};
  int cmod[2] = '{65536, 16};

  // reference model state
  int            mptr [2];
  int            mcnt [2];
  logic [DW-1:0] mdata[2];
  logic [3:0]    mval [2];
  logic          rdy_s[2];

  typedef struct {
    logic rst, v, md, clr;
    logic [3:0]  full;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [1:0]  ep;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, v, md, clr, input logic [3:0] full,
                              input logic [31:0] d, input logic rdy, input logic [3:0] ev,
                              input logic [31:0] ed, input logic [1:0] ep, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.v = v; t.md = md; t.clr = clr; t.full = full; t.d = d;
    t.rdy = rdy; t.ev = ev; t.ed = ed; t.ep = ep; t.ec = ec;
    return t;
  endfunction

  task automatic idle(input int k);
    vin[k] = 1'b0; mdin[k] = 1'b0; cin[k] = 1'b0; fin[k] = 4'h0; din[k] = '0;
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic step();
    logic [3:0] mask;
    logic       er;
    #1;
    for (int k = 0; k < 2; k++) begin
      mask     = 4'((1 << nch[k]) - 1);
      er       = mdin[k] ? ((fin[k] & mask) == 4'h0) : !fin[k][mptr[k]];
      rdy_s[k] = (k == 0) ? r0 : r1;
      check($sformatf("ready%0d", k), 64'(rdy_s[k]), 64'(er));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mask = 4'((1 << nch[k]) - 1);
      er   = mdin[k] ? ((fin[k] & mask) == 4'h0) : !fin[k][mptr[k]];
      if (rst) begin
        mptr[k] = 0; mcnt[k] = 0; mdata[k] = '0; mval[k] = 4'h0;
      end else begin
        mval[k] = 4'h0;
        if (vin[k] && er) begin
          mdata[k] = din[k];
          mval[k]  = mdin[k] ? mask : 4'(1 << mptr[k]);
        end
        if (cin[k]) begin
          mptr[k] = 0; mcnt[k] = 0;
        end else if (vin[k] && er) begin
          mcnt[k] = (mcnt[k] + 1) % cmod[k];
          if (!mdin[k]) mptr[k] = (mptr[k] + 1) % nch[k];
        end
      end
    end
    #1;
    check("data0",  64'(q0),  64'(mdata[0]));
    check("valid0", 64'(qv0), 64'(mval[0]));
    check("ptr0",   64'(p0),  64'(mptr[0]));
    check("cnt0",   64'(bc0), 64'(mcnt[0]));
    check("data1",  64'(q1),  64'(mdata[1]));
    check("valid1", 64'(qv1), 64'(mval[1]));
    check("ptr1",   64'(p1),  64'(mptr[1]));
    check("cnt1",   64'(bc1), 64'(mcnt[1]));
  endtask

  initial begin
    rst = 1'b1;
    idle(0); idle(1);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mptr[k] = 0; mcnt[k] = 0; mdata[k] = '0; mval[k] = 4'h0;
    end
    check("rst_data0",  64'(q0),  64'h0);
    check("rst_valid0", 64'(qv0), 64'h0);
    check("rst_ptr0",   64'(p0),  64'h0);
    check("rst_cnt0",   64'(bc0), 64'h0);
    check("rst_valid1", 64'(qv1), 64'h0);
    check("rst_ptr1",   64'(p1),  64'h0);
    rst = 1'b0;

    // rst v md clr full data | rdy valid data ptr cnt
    tbl.push_back(mk(0,1,0,0,4'h0,32'd1, 1,4'b0001,32'd1,2'd1,16'd1));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd2, 1,4'b0010,32'd2,2'd2,16'd2));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd3, 1,4'b0100,32'd3,2'd3,16'd3));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd4, 1,4'b1000,32'd4,2'd0,16'd4));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd5, 1,4'b0001,32'd5,2'd1,16'd5));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd6, 1,4'b0010,32'd6,2'd2,16'd6));
    tbl.push_back(mk(0,1,0,1,4'h0,32'd7, 1,4'b0100,32'd7,2'd0,16'd0));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd8, 1,4'b0001,32'd8,2'd1,16'd1));
    tbl.push_back(mk(0,1,0,0,4'b0010,32'd9, 0,4'b0000,32'd8,2'd1,16'd1));
    tbl.push_back(mk(0,1,0,0,4'b0010,32'd9, 0,4'b0000,32'd8,2'd1,16'd1));
    tbl.push_back(mk(0,1,0,0,4'b0010,32'd9, 0,4'b0000,32'd8,2'd1,16'd1));
    tbl.push_back(mk(0,1,0,0,4'h0,32'd9, 1,4'b0010,32'd9,2'd2,16'd2));
    tbl.push_back(mk(0,0,0,0,4'h0,32'd0, 1,4'b0000,32'd9,2'd2,16'd2));
    tbl.push_back(mk(0,0,1,0,4'b0001,32'd0, 0,4'b0000,32'd9,2'd2,16'd2));
    tbl.push_back(mk(0,1,1,0,4'b0100,32'hA5, 0,4'b0000,32'd9,2'd2,16'd2));
    tbl.push_back(mk(0,1,1,0,4'b0100,32'hA5, 0,4'b0000,32'd9,2'd2,16'd2));
    tbl.push_back(mk(0,1,1,0,4'h0,32'hA5, 1,4'b1111,32'hA5,2'd2,16'd3));
    tbl.push_back(mk(0,1,0,0,4'b1011,32'h33, 1,4'b0100,32'h33,2'd3,16'd4));
    tbl.push_back(mk(1,1,0,0,4'h0,32'h44, 1,4'b0000,32'd0,2'd0,16'd0));
    tbl.push_back(mk(0,1,0,0,4'h0,32'h55, 1,4'b0001,32'h55,2'd1,16'd1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      vin[0] = tbl[i].v; mdin[0] = tbl[i].md; cin[0] = tbl[i].clr;
      fin[0] = tbl[i].full; din[0] = tbl[i].d;
      step();
      check($sformatf("tbl%0d_ready", i), 64'(rdy_s[0]), 64'(tbl[i].rdy));
      check($sformatf("tbl%0d_valid", i), 64'(qv0), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_data", i),  64'(q0),  64'(tbl[i].ed));
      check($sformatf("tbl%0d_ptr", i),   64'(p0),  64'(tbl[i].ep));
      check($sformatf("tbl%0d_cnt", i),   64'(bc0), 64'(tbl[i].ec));
    end
    rst = 1'b0;
    idle(0);

    // three lanes: pointer must wrap 2 -> 0 and never show 3
    for (int i = 0; i < 7; i++) begin
      check($sformatf("n3_ptr_pre%0d", i), 64'(p1), 64'(i % 3));
      vin[1] = 1'b1; din[1] = 32'(100 + i);
      step();
      check($sformatf("n3_valid%0d", i), 64'(qv1), 64'(1 << (i % 3)));
      check($sformatf("n3_data%0d", i),  64'(q1),  64'(100 + i));
    end
    idle(1);

    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(63) == 0);
      for (int k = 0; k < 2; k++) begin
        vin[k] = ($urandom_range(3) != 0);
        if ($urandom_range(15) == 0) mdin[k] = ~mdin[k];
        cin[k] = ($urandom_range(15) == 0);
        fin[k] = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
        din[k] = $urandom;
      end
      fin[1][3] = 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
